// File: rtl/sensor_req_pkg.sv
// Shared types and helpers for the sensor request latch: channel state encoding,
// index-width helper and saturating age increment.
package sensor_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    PENDING = 2'd2
  } chan_state_e;

  // Width of a channel index; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Increment an age of the given width, sticking at all-ones.
  function automatic logic [31:0] age_sat_inc(input logic [31:0] age, input int width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (age >= max_v) ? max_v : age + 32'd1;
  endfunction

endpackage

// File: rtl/sensor_req_chan.sv
// One sensor channel: debounce, sticky request latch and saturating wait age.
// Optional STARVE flag built when SENSOR_REQ_STARVE_EN is defined.
module sensor_req_chan
  import sensor_req_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int AGE_W    = 8
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             sense,
  input  logic             clear,
  output logic             req,
`ifdef SENSOR_REQ_STARVE_EN
  output logic             starve,
`endif
  output logic [AGE_W-1:0] age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);

  chan_state_e      state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [3:0]       cnt_inc;
  logic [AGE_W-1:0] age_r, age_n;

  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 4'd0;
      age_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      age_r <= age_n;
    end
  end

  // CLEAR outranks everything, so a held CLEAR also keeps the channel from arming.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    age_n   = age_r;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      age_n   = '0;
    end else begin
      case (state)
        IDLE, ARMING: begin
          age_n = '0;
          if (sense) begin
            if (cnt_inc == DEB) begin
              state_n = PENDING;
              cnt_n   = 4'd0;
            end else begin
              state_n = ARMING;
              cnt_n   = cnt_inc;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        end
        PENDING: begin
          cnt_n = 4'd0;
          age_n = AGE_W'(age_sat_inc(32'(age_r), AGE_W));
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          age_n   = '0;
        end
      endcase
    end
  end

  assign req = (state == PENDING);
  assign age = age_r;

`ifdef SENSOR_REQ_STARVE_EN
  // Flag is computed from next-state values so it rises with the age reaching max.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      starve <= 1'b0;
    end else if (clear) begin
      starve <= 1'b0;
    end else if (state_n == PENDING && age_n == AGE_MAX) begin
      starve <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sensor_req_latch.sv
// N-channel sensor request latch with oldest-pending-channel selection.
// Define SENSOR_REQ_STARVE_EN to add the registered STARVE output.
module sensor_req_latch
  import sensor_req_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DEBOUNCE = 3,
  parameter int AGE_W    = 8
) (
  input  logic                            MCLK,
  input  logic                            RESET,
  input  logic [NUM_CH-1:0]               SENSE_IN,
  input  logic [NUM_CH-1:0]               CLEAR,
  output logic [NUM_CH-1:0]               REQ_OUT,
  output logic [NUM_CH*AGE_W-1:0]         AGE_OUT,
`ifdef SENSOR_REQ_STARVE_EN
  output logic [NUM_CH-1:0]               STARVE,
`endif
  output logic                            OLDEST_VALID,
  output logic [idx_width(NUM_CH)-1:0]    OLDEST_IDX
);

  localparam int IDX_W = idx_width(NUM_CH);

  logic [AGE_W-1:0] age_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    sensor_req_chan #(
      .DEBOUNCE (DEBOUNCE),
      .AGE_W    (AGE_W)
    ) u_chan (
      .MCLK   (MCLK),
      .RESET  (RESET),
      .sense  (SENSE_IN[i]),
      .clear  (CLEAR[i]),
      .req    (REQ_OUT[i]),
`ifdef SENSOR_REQ_STARVE_EN
      .starve (STARVE[i]),
`endif
      .age    (age_arr[i])
    );
    assign AGE_OUT[i*AGE_W +: AGE_W] = age_arr[i];
  end

  // Strict greater-than while scanning upward keeps ties on the lowest index.
  logic             found;
  logic [AGE_W-1:0] best_age;
  logic [IDX_W-1:0] best_idx;

  always_comb begin
    found    = 1'b0;
    best_age = '0;
    best_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (REQ_OUT[i] && (!found || age_arr[i] > best_age)) begin
        found    = 1'b1;
        best_age = age_arr[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  assign OLDEST_VALID = found;
  assign OLDEST_IDX   = best_idx;

endmodule

// File: tb/tb_sensor_req_latch.sv
// Directed bench for sensor_req_latch: a 4-channel DEBOUNCE=3 AGE_W=4 instance
// and a 2-channel legacy DEBOUNCE=1 instance.
module tb_sensor_req_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sense, clr;
  logic [3:0]  req;
  logic [15:0] ages;
  logic        ov;
  logic [1:0]  oidx;
  logic [1:0]  sense2, clr2;
  logic [1:0]  req2;
  logic [15:0] ages2;
  logic        ov2;
  logic [0:0]  oidx2;
`ifdef SENSOR_REQ_STARVE_EN
  logic [3:0]  starve;
  logic [1:0]  starve2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_req_latch #(.NUM_CH(4), .DEBOUNCE(3), .AGE_W(4)) dut (
    .MCLK(clk), .RESET(rst), .SENSE_IN(sense), .CLEAR(clr),
    .REQ_OUT(req), .AGE_OUT(ages),
`ifdef SENSOR_REQ_STARVE_EN
    .STARVE(starve),
`endif
    .OLDEST_VALID(ov), .OLDEST_IDX(oidx)
  );

  sensor_req_latch #(.NUM_CH(2), .DEBOUNCE(1), .AGE_W(8)) dut_leg (
    .MCLK(clk), .RESET(rst), .SENSE_IN(sense2), .CLEAR(clr2),
    .REQ_OUT(req2), .AGE_OUT(ages2),
`ifdef SENSOR_REQ_STARVE_EN
    .STARVE(starve2),
`endif
    .OLDEST_VALID(ov2), .OLDEST_IDX(oidx2)
  );

  function automatic logic [3:0] age_of(input int ch);
    return ages[ch*4 +: 4];
  endfunction

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sense = '0; clr = '0; sense2 = '0; clr2 = '0;
    tick(2);
    checks++;
    if (req !== 4'b0 || ages !== 16'h0 || ov !== 1'b0 || oidx !== 2'd0) begin
      errors++;
      $display("FAIL reset_main got req=%b ages=%h ov=%b idx=%0d required 0", req, ages, ov, oidx);
    end
    checks++;
    if (req2 !== 2'b0 || ages2 !== 16'h0 || ov2 !== 1'b0 || oidx2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_legacy got req=%b ages=%h ov=%b required 0", req2, ages2, ov2);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_debounce;
    sense[0] = 1'b1; tick(2);
    sense[0] = 1'b0; tick(1);
    checks++;
    if (req[0] !== 1'b0) begin
      errors++; $display("FAIL deb_broken got %b required 0", req[0]);
    end
    sense[0] = 1'b1; tick(2);
    checks++;
    if (req[0] !== 1'b0) begin
      errors++; $display("FAIL deb_two_high got %b required 0", req[0]);
    end
    tick(1);
    checks++;
    if (req[0] !== 1'b1 || age_of(0) !== 4'd0) begin
      errors++; $display("FAIL deb_latch got req=%b age=%0d required req=1 age=0", req[0], age_of(0));
    end
    tick(1);
    checks++;
    if (req[0] !== 1'b1 || age_of(0) !== 4'd1) begin
      errors++; $display("FAIL deb_age1 got req=%b age=%0d required req=1 age=1", req[0], age_of(0));
    end
    sense[0] = 1'b0; clr[0] = 1'b1; tick(1);
    clr[0] = 1'b0;
    checks++;
    if (req[0] !== 1'b0 || age_of(0) !== 4'd0) begin
      errors++; $display("FAIL deb_clear got req=%b age=%0d required 0", req[0], age_of(0));
    end
  endtask

  task automatic test_clear_priority;
    sense[1] = 1'b1; tick(5);
    checks++;
    if (req[1] !== 1'b1 || age_of(1) !== 4'd2) begin
      errors++; $display("FAIL clr_setup got req=%b age=%0d required req=1 age=2", req[1], age_of(1));
    end
    clr[1] = 1'b1; tick(1);
    clr[1] = 1'b0;
    checks++;
    if (req[1] !== 1'b0 || age_of(1) !== 4'd0) begin
      errors++; $display("FAIL clr_with_sense got req=%b age=%0d required 0", req[1], age_of(1));
    end
    tick(2);
    checks++;
    if (req[1] !== 1'b0) begin
      errors++; $display("FAIL clr_rearm_early got %b required 0", req[1]);
    end
    tick(1);
    checks++;
    if (req[1] !== 1'b1) begin
      errors++; $display("FAIL clr_rearm got %b required 1", req[1]);
    end
    clr[1] = 1'b1; tick(4);
    checks++;
    if (req[1] !== 1'b0) begin
      errors++; $display("FAIL clr_held_block got %b required 0", req[1]);
    end
    clr[1] = 1'b0; sense[1] = 1'b0; tick(1);
  endtask

  task automatic test_oldest;
    sense[2] = 1'b1; tick(3);
    sense[2] = 1'b0; tick(2);
    sense[0] = 1'b1; tick(3);
    sense[0] = 1'b0;
    checks++;
    if (ov !== 1'b1 || oidx !== 2'd2 || age_of(2) !== 4'd5 || age_of(0) !== 4'd0) begin
      errors++;
      $display("FAIL oldest_ch2 got ov=%b idx=%0d a2=%0d a0=%0d required 1 2 5 0", ov, oidx, age_of(2), age_of(0));
    end
    clr[2] = 1'b1; tick(1);
    clr[2] = 1'b0;
    checks++;
    if (ov !== 1'b1 || oidx !== 2'd0 || req !== 4'b0001) begin
      errors++; $display("FAIL oldest_ch0 got ov=%b idx=%0d req=%b required 1 0 0001", ov, oidx, req);
    end
    clr[0] = 1'b1; sense[1] = 1'b1; sense[3] = 1'b1; tick(3);
    clr[0] = 1'b0; sense = '0;
    checks++;
    if (req !== 4'b1010 || oidx !== 2'd1 || age_of(1) !== 4'd0 || age_of(3) !== 4'd0) begin
      errors++; $display("FAIL oldest_tie got req=%b idx=%0d required 1010 1", req, oidx);
    end
    tick(1);
    checks++;
    if (oidx !== 2'd1 || age_of(3) !== 4'd1) begin
      errors++; $display("FAIL oldest_tie_age got idx=%0d a3=%0d required 1 1", oidx, age_of(3));
    end
    clr = 4'hf; tick(1);
    clr = '0;
    checks++;
    if (ov !== 1'b0 || oidx !== 2'd0 || req !== 4'b0) begin
      errors++; $display("FAIL oldest_none got ov=%b idx=%0d req=%b required 0 0 0000", ov, oidx, req);
    end
  endtask

  task automatic test_saturation;
    sense[3] = 1'b1; tick(3);
    sense[3] = 1'b0; tick(14);
    checks++;
    if (req[3] !== 1'b1 || age_of(3) !== 4'd14) begin
      errors++; $display("FAIL sat_14 got req=%b age=%0d required 1 14", req[3], age_of(3));
    end
`ifdef SENSOR_REQ_STARVE_EN
    checks++;
    if (starve[3] !== 1'b0) begin
      errors++; $display("FAIL starve_early got %b required 0", starve[3]);
    end
`endif
    tick(1);
    checks++;
    if (age_of(3) !== 4'd15) begin
      errors++; $display("FAIL sat_15 got %0d required 15", age_of(3));
    end
`ifdef SENSOR_REQ_STARVE_EN
    checks++;
    if (starve[3] !== 1'b1) begin
      errors++; $display("FAIL starve_set got %b required 1", starve[3]);
    end
`endif
    tick(5);
    checks++;
    if (age_of(3) !== 4'd15 || req[3] !== 1'b1) begin
      errors++; $display("FAIL sat_hold got age=%0d req=%b required 15 1", age_of(3), req[3]);
    end
    clr[3] = 1'b1; tick(1);
    clr[3] = 1'b0;
    checks++;
    if (age_of(3) !== 4'd0 || req[3] !== 1'b0) begin
      errors++; $display("FAIL sat_clear got age=%0d req=%b required 0 0", age_of(3), req[3]);
    end
`ifdef SENSOR_REQ_STARVE_EN
    checks++;
    if (starve[3] !== 1'b0) begin
      errors++; $display("FAIL starve_clear got %b required 0", starve[3]);
    end
`endif
  endtask

  task automatic test_legacy;
    sense2[0] = 1'b1; tick(1);
    sense2[0] = 1'b0;
    checks++;
    if (req2 !== 2'b01 || ages2[7:0] !== 8'd0 || ov2 !== 1'b1 || oidx2 !== 1'b0) begin
      errors++; $display("FAIL legacy_set got req=%b age=%0d required 01 0", req2, ages2[7:0]);
    end
    tick(3);
    checks++;
    if (req2 !== 2'b01 || ages2[7:0] !== 8'd3) begin
      errors++; $display("FAIL legacy_hold got req=%b age=%0d required 01 3", req2, ages2[7:0]);
    end
    clr2[0] = 1'b1; tick(1);
    clr2[0] = 1'b0;
    checks++;
    if (req2 !== 2'b00 || ages2 !== 16'h0 || ov2 !== 1'b0) begin
      errors++; $display("FAIL legacy_clear got req=%b ages=%h required 00 0", req2, ages2);
    end
  endtask

  task automatic test_async_reset;
    sense = 4'b1010; tick(3);
    sense = '0; tick(2);
    checks++;
    if (req !== 4'b1010 || age_of(1) !== 4'd2) begin
      errors++; $display("FAIL areset_setup got req=%b a1=%0d required 1010 2", req, age_of(1));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req !== 4'b0 || ages !== 16'h0 || ov !== 1'b0 || oidx !== 2'd0) begin
      errors++; $display("FAIL areset_async got req=%b ages=%h ov=%b idx=%0d required 0", req, ages, ov, oidx);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++;
    if (req !== 4'b0 || ov !== 1'b0) begin
      errors++; $display("FAIL areset_release got req=%b ov=%b required 0", req, ov);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clear_priority();
    test_oldest();
    test_saturation();
    test_legacy();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_req_latch.md
Name: sensor_req_latch

Overview:
- N-channel generalisation of the traffic-light sensor request register.
- Each channel debounces a raw vehicle-sensor input and latches a pending request until the controller signals that the channel was served (CLEAR).
- Tracks how long each request has waited and reports the oldest pending channel to the light-sequencing FSM.
- Sits between the sensor pins and the traffic-light controller FSM.

Parameters:
- NUM_CH, 4: number of sensor channels; legal range 1..16.
- DEBOUNCE, 3: consecutive high samples required to latch a request; legal range 1..15. A value of 1 gives legacy behaviour: set on the first sample.
- AGE_W, 8: width of each per-channel wait-age counter.

Ports:
- MCLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SENSE_IN  in  NUM_CH  raw sensor inputs; already synchronous to MCLK.
- CLEAR  in  NUM_CH  per-channel "served / left" pulse or level from the controller.
- REQ_OUT  out  NUM_CH  latched pending requests.
- AGE_OUT  out  NUM_CH*AGE_W  per-channel wait ages; channel i occupies bits [i*AGE_W +: AGE_W].
- OLDEST_VALID  out  1  high when any REQ_OUT bit is set.
- OLDEST_IDX  out  max(1,$clog2(NUM_CH))  index of the pending channel with the largest age.

Behaviour:
- Reset: asynchronous; REQ_OUT=0, all ages=0, all debounce counters=0, OLDEST_VALID=0, OLDEST_IDX=0.
- Per-channel state is one of IDLE, ARMING or PENDING.
  - IDLE → ARMING on the first sampled SENSE_IN=1.
  - ARMING → PENDING when the debounce counter reaches DEBOUNCE.
  - PENDING → IDLE only on CLEAR.
- Debounce counter:
  - Increments on each edge with SENSE_IN=1 while not PENDING.
  - Resets to 0 on any edge with SENSE_IN=0.
  - REQ_OUT sets on the edge where the count of consecutive high samples reaches DEBOUNCE. With DEBOUNCE=3 and SENSE_IN high at edges 1, 2 and 3, REQ_OUT rises after edge 3.
  - Counter is held at 0 while PENDING.
- Once PENDING, SENSE_IN is ignored; the request is sticky.
- CLEAR priority:
  - CLEAR=1 on an edge forces REQ_OUT=0, age=0 and debounce count=0, regardless of SENSE_IN. This covers the "clear and sense together → 0" rule.
  - A held CLEAR blocks re-arming for as long as it is held.
- Age counter:
  - 0 while not PENDING.
  - Becomes 0 on the edge REQ_OUT sets.
  - Increments by 1 on each subsequent edge while PENDING.
  - Saturates at 2^AGE_W-1 and never wraps.
- Oldest selection:
  - Combinational from registered REQ_OUT and ages; no added latency.
  - Selects the maximum age among pending channels; ties go to the lowest index.
  - OLDEST_IDX=0 when OLDEST_VALID=0.
- Channels are fully independent; simultaneous sets or clears on multiple channels are all honoured on the same edge.
- Reset mid-debounce or mid-wait discards all state immediately; there is no pending carry-over.

Optional Feature:
- Macro: SENSOR_REQ_STARVE_EN.
- When defined, adds output STARVE (NUM_CH bits), registered.
  - STARVE[i] sets when age[i] reaches 2^AGE_W-1 while PENDING.
  - Cleared by CLEAR[i] or RESET.
  - Drives the controller's forced-service override.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sensor_req_pkg:
  - Per-channel state enum: IDLE, ARMING, PENDING.
  - Localparam helper for the index width.
  - Age saturation function.
- Sub-module sensor_req_chan: one channel's debounce, latch and age logic.
  - Instanced NUM_CH times via generate.
  - The top level adds the oldest-channel comparator tree.

Test Plan:
- Reset: assert RESET mid-run with REQ_OUT=4'b1010 → all outputs 0 asynchronously, before the next MCLK edge.
- Debounce (DEBOUNCE=3): SENSE_IN[0] high for 2 cycles, low 1, high 3 → REQ_OUT[0] rises only after the 3rd consecutive high; AGE_OUT[0]=0 on that cycle.
- Clear priority: ch1 PENDING; drive SENSE_IN[1]=1 and CLEAR[1]=1 together for 1 cycle → REQ_OUT[1]=0, age 0. Then SENSE_IN[1] held high → re-latched 3 cycles after CLEAR drops.
- Oldest: ch2 latched 5 cycles before ch0 → OLDEST_IDX=2. Clear ch2 → OLDEST_IDX=0. Latch ch1 and ch3 on the same edge with ch0 cleared → OLDEST_IDX=1.
- Saturation (AGE_W=4): hold ch3 PENDING for 20 cycles → AGE_OUT[3] stops at 15. With SENSOR_REQ_STARVE_EN defined, STARVE[3]=1 from the cycle age hits 15 until CLEAR[3].
- Legacy (NUM_CH=2, DEBOUNCE=1): single-cycle SENSE_IN pulse → REQ_OUT set next edge and held until CLEAR.
